// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler
//
// Shares the single 320x240 VGA pixel-write port among the falling-note
// lanes. Every beat starts a pass that walks the lanes in order: an active
// note box is erased, moved down by FALL_STEP, then redrawn or retired at
// the hit line. An idle lane with a pending spawn request gets a new box
// at the top of the screen.
//
// Ports
//   clk              system clock
//   resetn           asynchronous active-low reset
//   i_beat           1-cycle beat pulse
//   i_notes          spawn requests, one bit per lane, sampled with i_beat
//   o_x, o_y         pixel coordinate
//   o_colour         pixel colour
//   o_plot           pixel write strobe
//   o_notes_to_play  1-cycle pulse on bit k when lane k's note retires
//   o_busy           high while a pass is in progress
//   o_overrun        1-cycle pulse when a beat is dropped
//
// Handshake: there is no back-pressure on either side. i_beat is a
// fire-and-forget pulse; at most one beat is remembered while a pass runs
// (pending) and any further beat is dropped with o_overrun. Each cycle with
// o_plot=1 is one pixel write that the VGA adapter must accept.
//
// All outputs are registered from the next-state values, so the pixel on
// o_x/o_y/o_colour lines up with the cycle in which the state register
// holds ERASE or DRAW.

module note_lane_scheduler #(
    parameter int          NUM_LANES   = 5,
    parameter int          LANE_X0     = 96,
    parameter int          LANE_PITCH  = 32,
    parameter int          BOX_W       = 16,
    parameter int          BOX_H       = 4,
    parameter int          FALL_STEP   = 4,
    parameter int          HIT_Y       = 200,
    parameter logic [8:0]  NOTE_COLOUR = 9'h1FF,
    parameter logic [8:0]  BG_COLOUR   = 9'h000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_beat,
    input  logic [NUM_LANES-1:0] i_notes,
    output logic [8:0]           o_x,
    output logic [7:0]           o_y,
    output logic [8:0]           o_colour,
    output logic                 o_plot,
    output logic [NUM_LANES-1:0] o_notes_to_play,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int LANE_W = 3;
    localparam int CX_W   = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int CY_W   = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [CX_W-1:0]   LAST_CX   = CX_W'(BOX_W - 1);
    localparam logic [CY_W-1:0]   LAST_CY   = CY_W'(BOX_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_ERASE = 3'd2,
        S_MOVE  = 3'd3,
        S_DRAW  = 3'd4
    } state_t;

    // Left edge of a lane, computed in 9 bits so it covers the full 320-pixel width.
    function automatic logic [8:0] f_lane_x(input logic [LANE_W-1:0] lane);
        return 9'(LANE_X0) + 9'(lane) * 9'(LANE_PITCH);
    endfunction

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [LANE_W-1:0]     r_lane;
    logic [CX_W-1:0]       r_cx;
    logic [CY_W-1:0]       r_cy;
    logic [NUM_LANES-1:0]  r_active;
    logic [NUM_LANES-1:0]  r_spawn;
    logic                  r_pending;
    logic [7:0]            r_ypos [NUM_LANES];

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                w_state_nx;
    logic [LANE_W-1:0]     w_lane_nx;
    logic [CX_W-1:0]       w_cx_nx;
    logic [CY_W-1:0]       w_cy_nx;
    logic [NUM_LANES-1:0]  w_active_nx;
    logic [NUM_LANES-1:0]  w_spawn_nx;
    logic [NUM_LANES-1:0]  w_spawn_clr;
    logic                  w_pending_nx;
    logic [7:0]            w_ypos_nx [NUM_LANES];
    logic [NUM_LANES-1:0]  w_retire;
    logic                  w_overrun;
    logic                  w_advance;
    logic                  w_box_done;
    logic [8:0]            w_ny;
    logic [NUM_LANES-1:0]  w_beat_notes;

    logic                  w_plot_nx;
    logic [8:0]            w_px_x;
    logic [7:0]            w_px_y;
    logic [8:0]            w_px_colour;

    assign w_box_done   = (r_cx == LAST_CX) && (r_cy == LAST_CY);
    // 9-bit sum so a box near the bottom cannot wrap back to the top.
    assign w_ny         = {1'b0, r_ypos[r_lane]} + 9'(FALL_STEP);
    assign w_beat_notes = i_beat ? i_notes : '0;

    always_comb begin
        w_state_nx   = r_state;
        w_lane_nx    = r_lane;
        w_cx_nx      = r_cx;
        w_cy_nx      = r_cy;
        w_active_nx  = r_active;
        w_ypos_nx    = r_ypos;
        w_pending_nx = r_pending;
        w_spawn_clr  = '0;
        w_retire     = '0;
        w_overrun    = 1'b0;
        w_advance    = 1'b0;

        // A beat arriving mid-pass is remembered once; a second one is dropped.
        if (i_beat && (r_state != S_IDLE)) begin
            if (!r_pending) begin
                w_pending_nx = 1'b1;
            end else begin
                w_overrun = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (i_beat || r_pending) begin
                    w_lane_nx    = '0;
                    w_pending_nx = 1'b0;
                    w_state_nx   = S_SCAN;
                end
            end

            S_SCAN: begin
                // The request is consumed whatever happens, so a spawn on an
                // already active lane is discarded rather than queued.
                w_spawn_clr[r_lane] = 1'b1;
                w_cx_nx             = '0;
                w_cy_nx             = '0;
                if (r_active[r_lane]) begin
                    w_state_nx = S_ERASE;
                end else if (r_spawn[r_lane]) begin
                    w_ypos_nx[r_lane]   = 8'd0;
                    w_active_nx[r_lane] = 1'b1;
                    w_state_nx          = S_DRAW;
                end else begin
                    w_advance = 1'b1;
                end
            end

            S_ERASE, S_DRAW: begin
                if (w_box_done) begin
                    if (r_state == S_ERASE) begin
                        w_state_nx = S_MOVE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end else if (r_cx == LAST_CX) begin
                    w_cx_nx = '0;
                    w_cy_nx = r_cy + CY_W'(1);
                end else begin
                    w_cx_nx = r_cx + CX_W'(1);
                end
            end

            S_MOVE: begin
                w_cx_nx = '0;
                w_cy_nx = '0;
                if (w_ny >= 9'(HIT_Y)) begin
                    w_active_nx[r_lane] = 1'b0;
                    w_retire[r_lane]    = 1'b1;
                    w_advance           = 1'b1;
                end else begin
                    w_ypos_nx[r_lane] = w_ny[7:0];
                    w_state_nx        = S_DRAW;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Lane hand-off takes no cycle of its own. A beat landing on the last
        // cycle of a pass chains straight into the next pass.
        if (w_advance) begin
            if (r_lane == LAST_LANE) begin
                if (r_pending || i_beat) begin
                    w_lane_nx    = '0;
                    w_pending_nx = 1'b0;
                    w_state_nx   = S_SCAN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end else begin
                w_lane_nx  = r_lane + LANE_W'(1);
                w_state_nx = S_SCAN;
            end
        end

        // Clear before OR so a request arriving in the lane's own SCAN cycle
        // survives until the next pass.
        w_spawn_nx = (r_spawn & ~w_spawn_clr) | w_beat_notes;
    end

    // Pixel presented in the cycle the state register enters ERASE/DRAW.
    always_comb begin
        w_plot_nx   = (w_state_nx == S_ERASE) || (w_state_nx == S_DRAW);
        w_px_x      = f_lane_x(w_lane_nx) + 9'(w_cx_nx);
        w_px_y      = w_ypos_nx[w_lane_nx] + 8'(w_cy_nx);
        w_px_colour = (w_state_nx == S_DRAW) ? NOTE_COLOUR : BG_COLOUR;
    end

    // ------------------------------------------------------------------
    // Registers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_lane          <= '0;
            r_cx            <= '0;
            r_cy            <= '0;
            r_active        <= '0;
            r_spawn         <= '0;
            r_pending       <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                r_ypos[k] <= 8'd0;
            end
            o_x             <= 9'd0;
            o_y             <= 8'd0;
            o_colour        <= 9'd0;
            o_plot          <= 1'b0;
            o_notes_to_play <= '0;
            o_busy          <= 1'b0;
            o_overrun       <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_lane          <= w_lane_nx;
            r_cx            <= w_cx_nx;
            r_cy            <= w_cy_nx;
            r_active        <= w_active_nx;
            r_spawn         <= w_spawn_nx;
            r_pending       <= w_pending_nx;
            r_ypos          <= w_ypos_nx;
            o_plot          <= w_plot_nx;
            o_busy          <= (w_state_nx != S_IDLE);
            o_notes_to_play <= w_retire;
            o_overrun       <= w_overrun;
            // Coordinates hold their last value between boxes.
            if (w_plot_nx) begin
                o_x      <= w_px_x;
                o_y      <= w_px_y;
                o_colour <= w_px_colour;
            end
        end
    end

endmodule

// File: doc/note_lane_scheduler.md
# note_lane_scheduler

Sequences the single VGA pixel-write port among the five note lanes of the falling-note display. On each beat pulse it walks lanes 0..4 in fixed order: it erases each active note box, advances it down by a fixed step, then redraws it or retires it at the hit line. It also spawns newly requested notes at the top of idle lanes. It sits between the beat/note source and the 320x240 VGA adapter, and it produces the per-lane `notes_to_play` pulses.

## Interface
- `NUM_LANES`, 5, number of lanes; the lane index is 3 bits wide.
- `LANE_X0`, 96, x of lane 0 left edge.
- `LANE_PITCH`, 32, x distance between lane left edges.
- `BOX_W`, 16, note box width in pixels.
- `BOX_H`, 4, note box height in pixels.
- `FALL_STEP`, 4, y advance per beat.
- `HIT_Y`, 200, y threshold at which a note retires.
- `NOTE_COLOUR`, 9'h1FF, draw colour.
- `BG_COLOUR`, 9'h000, erase colour.
- `clk` in 1: system clock (CLOCK_50 at top level).
- `resetn` in 1: asynchronous, active-low reset.
- `i_beat` in 1: 1-cycle beat pulse.
- `i_notes` in 5: spawn requests, sampled only when `i_beat`=1.
- `o_x` out 9: pixel x.
- `o_y` out 8: pixel y.
- `o_colour` out 9: pixel colour.
- `o_plot` out 1: pixel write strobe.
- `o_notes_to_play` out 5: 1-cycle pulse on bit k when lane k's note retires.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_overrun` out 1: 1-cycle pulse when a beat is dropped.

## Operation
- Per-lane state: `active[k]` (1 bit), `ypos[k]` (8 bits), `spawn[k]` (1 bit).
- Beat capture: on `i_beat`, `spawn |= i_notes`.
  - If in IDLE, the pass starts.
  - Else if `pending`=0, set `pending`=1.
  - Else pulse `o_overrun`; the beat is dropped, but its `i_notes` bits are still ORed into `spawn`.
- States:
  - IDLE: on `i_beat` or `pending`, set lane=0, clear `pending`, go to SCAN.
  - SCAN (1 cycle per lane), by priority:
    - `active` → ERASE.
    - else `spawn` → set `ypos`=0, `active`=1, go to DRAW.
    - else go to NEXT.
    - `spawn[lane]` is cleared in SCAN in every case; a spawn request on an active lane is discarded.
  - ERASE: BOX_W*BOX_H cycles at `BG_COLOUR` over the box at (`LANE_X0`+lane*`LANE_PITCH`, `ypos`), then MOVE.
  - MOVE (1 cycle): compute `ny` = `ypos` + `FALL_STEP` in 9 bits, so there is no 8-bit wrap.
    - If `ny` >= `HIT_Y`: clear `active`, pulse `o_notes_to_play[lane]`, go to NEXT.
    - Else set `ypos` = `ny`, go to DRAW.
  - DRAW: BOX_W*BOX_H cycles at `NOTE_COLOUR`, then NEXT.
  - NEXT is a transition, not a state, so it takes no cycle:
    - If lane = `NUM_LANES`-1: go to IDLE, or directly to SCAN lane 0 if `pending` (clearing `pending`).
    - Else lane+1 → SCAN.
- Pixel walk: row-major, with `cx` inner (0..BOX_W-1) and `cy` outer. `o_x` = lane_x+`cx`, `o_y` = `ypos`+`cy`.
- Widths: lane_x is computed in 9 bits. The parameters must satisfy `HIT_Y`+`BOX_H` <= 240 and `LANE_X0`+4*`LANE_PITCH`+`BOX_W` <= 320; no clipping is performed.

## Timing
- All outputs are registered. Reset values: `o_x`=0, `o_y`=0, `o_colour`=0, `o_plot`=0, `o_notes_to_play`=0, `o_busy`=0, `o_overrun`=0. All `active`, `spawn`, `ypos` and `pending` are 0, and the state is IDLE with lane=0.
- Beat at cycle N in IDLE → SCAN lane 0 at N+1.
- Each box takes exactly BOX_W*BOX_H consecutive cycles with `o_plot`=1. `o_plot`=0 in IDLE, SCAN and MOVE.
- An active non-retiring lane costs 1+64+1+64 = 130 cycles. A spawned lane costs 1+64. An idle lane costs 1. A retiring lane costs 1+64+1.
- `o_notes_to_play[k]` is high in the cycle after MOVE for lane k.
- A beat coinciding with the last cycle of a pass sets `pending`; the next pass starts without passing through IDLE.
- `resetn` low mid-pass: all registers clear immediately. Pixels already written stay on screen; erasing them is the background-redraw logic's job.

## Test plan
- Reset, then beat with `i_notes`=5'b00001 at cycle 0 → `o_busy`=1 for cycles 1..69. Cycles 2..65 have `o_plot`=1, `o_colour`=`NOTE_COLOUR`, x 96..111, y 0..3, row-major. `o_busy`=0 at cycle 70.
- Second beat with `i_notes`=0 → lane 0 erases x 96..111, y 0..3 at `BG_COLOUR`, then draws y 4..7. No other lane plots.
- Beats until lane 0 `ypos`=196 → the next beat erases, then pulses `o_notes_to_play`=5'b00001 for 1 cycle with no redraw. `active[0]`=0 afterwards.
- Beat with `i_notes`=5'b11111 → boxes are drawn at x 96, 128, 160, 192 and 224 in lane order with no gaps between boxes other than the SCAN cycles. Total busy time is 5*65 = 325 cycles.
- Two beats during one busy pass → the first sets `pending`, the second pulses `o_overrun`. Exactly one extra pass follows immediately.
- Assert `resetn`=0 mid-DRAW → all outputs are 0 in the same cycle. After release, a beat with `i_notes`=0 produces no plots.
